// File: rtl/spi_byte_rx.sv
// SPI byte receiver: shifts mosi on sck_pe while selected and queues completed bytes in a 2-entry FIFO.
// Optional sticky overrun flag and clear input exist only when SPI_RX_OVERRUN_EN is defined.
module spi_byte_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       mosi,
    input  logic       sck_pe,
    output logic [7:0] rx_data,
    output logic       rx_first,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       abort,
    output logic       busy
`ifdef SPI_RX_OVERRUN_EN
    ,
    output logic       overrun,
    input  logic       clr_overrun
`endif
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       first_pend;
    logic       shift_en;
    logic       abort_nxt;
    logic       byte_done;
    logic [7:0] byte_nxt;

    logic [7:0] slot0_data, slot1_data;
    logic       slot0_first, slot1_first;
    logic [1:0] fifo_cnt;
    logic       push, pop, drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Deselect takes priority: a sck_pe coinciding with cs_n high is never shifted in.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_n) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cs_n) begin
                    state_nxt = IDLE;
                    abort_nxt = (bit_cnt != 3'd0);
                end else begin
                    shift_en = sck_pe;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == SHIFT);
    assign byte_done = shift_en && (bit_cnt == 3'd7);
    assign byte_nxt  = {shreg[6:0], mosi};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            first_pend <= 1'b0;
            abort      <= 1'b0;
        end else begin
            abort <= abort_nxt;
            if ((state == SHIFT) && cs_n) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                shreg   <= byte_nxt;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if ((state == IDLE) && !cs_n) first_pend <= 1'b1;
            else if (byte_done)           first_pend <= 1'b0;
        end
    end

    assign push = byte_done;
    assign pop  = rx_valid && rx_ready;
    assign drop = push && !pop && (fifo_cnt == 2'd2);

    // Slot 0 is always the head; it is left untouched when the FIFO drains so rx_data holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot0_data  <= 8'd0;
            slot0_first <= 1'b0;
            slot1_data  <= 8'd0;
            slot1_first <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else if (push && pop) begin
            if (fifo_cnt == 2'd2) begin
                slot0_data  <= slot1_data;
                slot0_first <= slot1_first;
                slot1_data  <= byte_nxt;
                slot1_first <= first_pend;
            end else begin
                slot0_data  <= byte_nxt;
                slot0_first <= first_pend;
            end
        end else if (push) begin
            if (fifo_cnt == 2'd0) begin
                slot0_data  <= byte_nxt;
                slot0_first <= first_pend;
                fifo_cnt    <= 2'd1;
            end else if (fifo_cnt == 2'd1) begin
                slot1_data  <= byte_nxt;
                slot1_first <= first_pend;
                fifo_cnt    <= 2'd2;
            end
        end else if (pop) begin
            if (fifo_cnt == 2'd2) begin
                slot0_data  <= slot1_data;
                slot0_first <= slot1_first;
            end
            fifo_cnt <= fifo_cnt - 2'd1;
        end
    end

    assign rx_valid = (fifo_cnt != 2'd0);
    assign rx_data  = slot0_data;
    assign rx_first = slot0_first;

`ifdef SPI_RX_OVERRUN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx with a scoreboard queue checked on every FIFO pop.
// Overrun checks are compiled in only with SPI_RX_OVERRUN_EN.
module tb_spi_byte_rx;

    logic       clk = 1'b0;
    logic       reset, cs_n, mosi, sck_pe, rx_ready;
    logic [7:0] rx_data;
    logic       rx_first, rx_valid, abort, busy;
`ifdef SPI_RX_OVERRUN_EN
    logic       overrun, clr_overrun;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_item;
    int         pulses;

    spi_byte_rx dut (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .sck_pe   (sck_pe),
        .rx_data  (rx_data),
        .rx_first (rx_first),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .abort    (abort),
        .busy     (busy)
`ifdef SPI_RX_OVERRUN_EN
        ,
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        mosi   = b;
        sck_pe = 1'b1;
        @(negedge clk);
        sck_pe = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic watch_abort(input int cycles, output int p);
        p = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (abort) p++;
        end
    endtask

    // Scoreboard: each negedge with valid&ready is one handshake at the following posedge.
    always @(negedge clk) begin
        #1;
        if (!reset && rx_valid && rx_ready) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_pop observed=%0h expected=none", rx_data);
            end
            if (exp_q.size() != 0) begin
                exp_item = exp_q.pop_front();
                check("pop_data", {24'd0, rx_data}, {24'd0, exp_item[7:0]});
                check("pop_first", {31'd0, rx_first}, {31'd0, exp_item[8]});
            end
        end
    end

    initial begin
        reset = 1'b1; cs_n = 1'b1; mosi = 1'b0; sck_pe = 1'b0; rx_ready = 1'b0;
`ifdef SPI_RX_OVERRUN_EN
        clr_overrun = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_first", {31'd0, rx_first}, 32'd0);
        check("rst_abort", {31'd0, abort}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef SPI_RX_OVERRUN_EN
        check("rst_overrun", {31'd0, overrun}, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Single byte A5 with consumer ready
        exp_q.push_back({1'b1, 8'hA5});
        cs_n = 1'b0; rx_ready = 1'b1;
        @(negedge clk);
        check("busy_shift", {31'd0, busy}, 32'd1);
        send_bits(8'hA5, 7);
        check("a5_not_yet", {31'd0, rx_valid}, 32'd0);
        send_bit(1'b1);
        check("a5_valid", {31'd0, rx_valid}, 32'd1);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_first", {31'd0, rx_first}, 32'd1);
        cs_n = 1'b1;
        watch_abort(3, pulses);
        check("a5_no_abort", pulses, 32'd0);
        check("a5_idle", {31'd0, busy}, 32'd0);

        // Three bytes with consumer stalled: third is dropped
        exp_q.push_back({1'b1, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        rx_ready = 1'b0; cs_n = 1'b0;
        @(negedge clk);
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'h33, 8);
        check("full_valid", {31'd0, rx_valid}, 32'd1);
        check("full_head", {24'd0, rx_data}, 32'h11);
        check("full_first", {31'd0, rx_first}, 32'd1);
`ifdef SPI_RX_OVERRUN_EN
        check("ovr_set", {31'd0, overrun}, 32'd1);
        @(negedge clk); clr_overrun = 1'b1;
        @(negedge clk); clr_overrun = 1'b0;
        check("ovr_clr", {31'd0, overrun}, 32'd0);
`endif
        cs_n = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("drain_empty", {31'd0, rx_valid}, 32'd0);
        check("drain_hold", {24'd0, rx_data}, 32'h22);

        // Partial byte (5 bits) then deselect
        cs_n = 1'b0;
        @(negedge clk);
        send_bits(8'hFF, 5);
        cs_n = 1'b1;
        watch_abort(4, pulses);
        check("part_abort", pulses, 32'd1);
        check("part_valid", {31'd0, rx_valid}, 32'd0);
        exp_q.push_back({1'b1, 8'h3C});
        cs_n = 1'b0;
        @(negedge clk);
        send_bits(8'h3C, 8);
        check("3c_data", {24'd0, rx_data}, 32'h3C);
        check("3c_first", {31'd0, rx_first}, 32'd1);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);

        // Deselect coincident with 8th pulse
        cs_n = 1'b0;
        @(negedge clk);
        send_bits(8'hC0, 7);
        @(negedge clk);
        mosi = 1'b1; sck_pe = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        sck_pe = 1'b0;
        check("coinc_abort_now", {31'd0, abort}, 32'd1);
        watch_abort(3, pulses);
        check("coinc_abort_once", pulses, 32'd0);
        check("coinc_no_push", {31'd0, rx_valid}, 32'd0);

        // Full FIFO, completion coincides with pop
        exp_q.push_back({1'b1, 8'h5A});
        exp_q.push_back({1'b0, 8'hC3});
        exp_q.push_back({1'b0, 8'h96});
        rx_ready = 1'b0; cs_n = 1'b0;
        @(negedge clk);
        send_bits(8'h5A, 8);
        send_bits(8'hC3, 8);
        send_bits(8'h96, 7);
        @(negedge clk);
        mosi = 1'b0; sck_pe = 1'b1; rx_ready = 1'b1;
        @(negedge clk);
        sck_pe = 1'b0; rx_ready = 1'b0;
        check("pp_valid", {31'd0, rx_valid}, 32'd1);
        check("pp_head", {24'd0, rx_data}, 32'hC3);
`ifdef SPI_RX_OVERRUN_EN
        check("pp_no_ovr", {31'd0, overrun}, 32'd0);
`endif
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("pp_drained", {31'd0, rx_valid}, 32'd0);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset mid-transaction with one byte queued
        rx_ready = 1'b0; cs_n = 1'b0;
        @(negedge clk);
        send_bits(8'h77, 8);
        send_bits(8'hF0, 4);
        check("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_first", {31'd0, rx_first}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        watch_abort(3, pulses);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_busy", {31'd0, busy}, 32'd0);
        watch_abort(3, pulses);
        check("rst_no_abort", pulses, 32'd0);
        check("rel_reenter", {31'd0, busy}, 32'd1);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);

        // Post-reset sanity byte with random ready stalls
        exp_q.push_back({1'b1, 8'hE7});
        cs_n = 1'b0;
        @(negedge clk);
        send_bits(8'hE7, 8);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_byte_rx.md
SPI_BYTE_RX -- requirements
Module: spi_byte_rx

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: cs_n  input  1  SPI select, active-low, already synchronized to clk.
REQ-004 SHALL have port: mosi  input  1  SPI data, already synchronized with the same latency as sck_pe.
REQ-005 SHALL have port: sck_pe  input  1  single-cycle SCK rising-edge pulse from the edge-pulse stage.
REQ-006 SHALL have port: rx_data  output  8  byte at FIFO head.
REQ-007 SHALL have port: rx_first  output  1  head byte is the first byte after cs_n fell.
REQ-008 SHALL have port: rx_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port: rx_ready  input  1  consumer accepts head byte when rx_valid and rx_ready are both high.
REQ-010 SHALL have port: abort  output  1  one-cycle pulse when cs_n rises with a partial byte pending.
REQ-011 SHALL have port: busy  output  1  high while in SHIFT state.
REQ-012 SHALL have port (macro-dependent, see Configuration): overrun  output  1  sticky drop flag; clr_overrun  input  1  clears it.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (cs_n high) and SHIFT (cs_n low); IDLE->SHIFT when cs_n=0, SHIFT->IDLE when cs_n=1.
REQ-014 SHALL, in SHIFT on sck_pe=1, shift mosi into an 8-bit shift register (MSB first by default) and increment a 3-bit bit counter.
REQ-015 SHALL complete a byte on the sck_pe cycle where the counter equals 7; the counter wraps to 0.
REQ-016 SHALL push the completed byte plus its first flag into a 2-entry FIFO; rx_valid rises on the cycle after completion (latency 1 clk).
REQ-017 SHALL set rx_first on the first completed byte after each IDLE->SHIFT transition and clear it for subsequent bytes of that transaction.
REQ-018 SHALL ignore sck_pe in IDLE and in any cycle where cs_n=1 (cs_n wins over a simultaneous sck_pe).
REQ-019 SHALL, on SHIFT->IDLE with counter != 0, discard the partial byte, pulse abort for exactly one cycle, and reset the counter to 0; no abort when counter = 0.
REQ-020 SHALL pop the FIFO head when rx_valid=1 and rx_ready=1; rx_data/rx_first are undefined-free (hold last value) when rx_valid=0.
REQ-021 SHALL, when a push coincides with a pop on a full FIFO, accept the push with no drop.
REQ-022 SHALL, when a push occurs on a full FIFO without a pop, drop the new byte and keep FIFO contents unchanged.
REQ-023 SHALL keep byte order strictly FIFO; push and pop on a 1-entry FIFO leave occupancy 1.

Reset
REQ-024 SHALL, on reset, force: FSM=IDLE, counter=0, shift register=0, FIFO empty, rx_valid=0, rx_data=0, rx_first=0, abort=0, busy=0, overrun=0.
REQ-025 SHALL, on reset asserted mid-transaction, discard all pending bits and FIFO contents without pulsing abort; after release, re-enter SHIFT only via cs_n=0 sampled on a clock edge.

Configuration
REQ-026 SHALL, with macro SPI_RX_OVERRUN_EN defined, provide overrun set on any REQ-022 drop, held until clr_overrun=1 (clear wins over a simultaneous set: no, set wins) -- set wins over simultaneous clear.
REQ-027 SHALL, without SPI_RX_OVERRUN_EN, omit the overrun and clr_overrun ports and their logic; drop behaviour in REQ-022 is unchanged.

Verification
REQ-028 SHALL cover: cs_n=0, bits 1010_0101 on 8 sck_pe, rx_ready=1 -> rx_valid one cycle after 8th pulse, rx_data=8'hA5, rx_first=1.
REQ-029 SHALL cover: 3 bytes 8'h11,8'h22,8'h33 in one transaction with rx_ready=0 -> FIFO holds 8'h11,8'h22 (rx_first 1,0), 8'h33 dropped, overrun=1 (macro on); clr_overrun -> overrun=0.
REQ-030 SHALL cover: cs_n rises after 5 sck_pe -> abort pulses one cycle, rx_valid stays 0; next transaction byte 8'h3C received with rx_first=1.
REQ-031 SHALL cover: cs_n rising in same cycle as 8th sck_pe -> bit ignored, abort pulses, no byte pushed.
REQ-032 SHALL cover: FIFO full, byte completion coincident with rx_ready=1 -> head popped, new byte accepted, no overrun, order preserved.
REQ-033 SHALL cover: reset asserted after 4 sck_pe with one byte queued -> all outputs at REQ-024 values immediately, abort never pulses.
